// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: after init, grants the bus to refresh, write or read owners
// and muxes the owner's command/address onto the SDRAM pins, with a per-grant watchdog.
module sdram_arbit #(
  parameter int         TIMEOUT = 1023,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        ref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        flag_ref_end,
  input  logic        flag_wr_end,
  input  logic        flag_rd_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic        err_timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARBIT,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            last_grant;
  logic            owner_end;

  // Only the current owner's done pulse can release the bus.
  always_comb begin
    owner_end = 1'b0;
    case (state)
      AREF:    owner_end = flag_ref_end;
      WRITE:   owner_end = flag_wr_end;
      READ:    owner_end = flag_rd_end;
      default: owner_end = 1'b0;
    endcase
  end

  // last_grant is 1 after a write grant and 0 after a read grant.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      last_grant  <= 1'b0;
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ref_en      <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (flag_init_end) state <= ARBIT;
        end
        ARBIT: begin
          wd_cnt <= '0;
          if (ref_req) begin
            state  <= AREF;
            ref_en <= 1'b1;
          end else if (wr_req && (!rd_req || !last_grant)) begin
            state      <= WRITE;
            wr_en      <= 1'b1;
            last_grant <= 1'b1;
          end else if (rd_req) begin
            state      <= READ;
            rd_en      <= 1'b1;
            last_grant <= 1'b0;
          end
        end
        AREF, WRITE, READ: begin
          if (owner_end) begin
            state  <= ARBIT;
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            state       <= ARBIT;
            wd_cnt      <= '0;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 13'd0;
    case (state)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 13'd0;
      end
    endcase
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles in a grant state before forced return to ARBIT.
REQ-002 Parameter CMD_NOP, default 4'b0111: command driven while no owner holds the bus.
REQ-003 sclk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flag_init_end  in  1  init sequence complete (level).
REQ-006 init_cmd / init_addr  in  4 / 13  init block command/address.
REQ-007 ref_req, wr_req, rd_req  in  1 each  requests from refresh, write and read blocks (level, held until served).
REQ-008 flag_ref_end, flag_wr_end, flag_rd_end  in  1 each  owner-done pulses.
REQ-009 aref_cmd/aref_addr, wr_cmd/wr_addr, rd_cmd/rd_addr  in  4/13 each  per-owner command/address.
REQ-010 ref_en, wr_en, rd_en  out  1 each  grant pulses, registered.
REQ-011 sdram_cmd / sdram_addr  out  4 / 13  muxed SDRAM command/address.
REQ-012 err_timeout  out  1  one-cycle pulse on watchdog expiry, registered.

Function
REQ-013 FSM states SHALL be IDLE, ARBIT, AREF, WRITE, READ; one-hot or binary is an implementation choice.
REQ-014 IDLE -> ARBIT on the first cycle flag_init_end=1; flag_init_end is ignored after leaving IDLE.
REQ-015 In ARBIT, priority SHALL be ref_req > (wr_req/rd_req); refresh always wins when asserted.
REQ-016 With wr_req=rd_req=1 and ref_req=0, grant the requester not granted last (last_grant bit); single requester granted directly.
REQ-017 Grant: state moves ARBIT -> AREF/WRITE/READ on the next edge, and the matching *_en SHALL be high exactly that one cycle (first cycle in the grant state).
REQ-018 ARBIT with no request: stay in ARBIT, all *_en low.
REQ-019 Grant state -> ARBIT on the edge after its flag_*_end=1; no preemption (ref_req during WRITE/READ waits).
REQ-020 Min turnaround: end pulse in cycle N -> ARBIT in N+1 -> next grant state/en in N+2.
REQ-021 last_grant SHALL update only on WRITE/READ grants; refresh grants leave it unchanged.
REQ-022 Watchdog: counter clears on grant-state entry, increments each cycle in grant state; on reaching TIMEOUT without end pulse -> ARBIT next edge and err_timeout=1 for one cycle.
REQ-023 End pulse and timeout in same cycle: end pulse wins, err_timeout stays 0.
REQ-024 flag_*_end from a non-owner SHALL be ignored.
REQ-025 sdram_cmd/sdram_addr SHALL be combinational from state: IDLE -> init_*, AREF -> aref_*, WRITE -> wr_*, READ -> rd_*, ARBIT -> CMD_NOP / 13'd0.
REQ-026 Watchdog counter width SHALL be clog2(TIMEOUT+1); no wrap in normal operation.

Reset
REQ-027 Reset SHALL force state=IDLE, *_en=0, err_timeout=0, watchdog=0, last_grant=READ (so write wins first tie).
REQ-028 Reset mid-grant SHALL abort at once; next cycle sdram_cmd/addr = init_cmd/init_addr; no end pulse required.

Verification
REQ-029 reset 3 cycles, flag_init_end=1 at cycle 5 -> ARBIT cycle 6, sdram_cmd=4'b0111, sdram_addr=0.
REQ-030 ref_req=wr_req=rd_req=1 in ARBIT -> ref_en pulse, AREF; after flag_ref_end -> wr_en; after flag_wr_end -> rd_en.
REQ-031 wr_req,rd_req held high, ends returned promptly -> grants alternate W,R,W,R; ref_req raised mid-WRITE served only after flag_wr_end.
REQ-032 TIMEOUT=8, WRITE granted, no flag_wr_end -> ARBIT after 8 cycles in WRITE, err_timeout one pulse; end+timeout same cycle -> no err.
REQ-033 reset asserted during READ with rd_cmd=4'b0101 -> next cycle state IDLE, rd_en=0, sdram_cmd=init_cmd.
